// File: rtl/conv_fetch_pkg.sv
// Shared defaults, state encoding and flow-control helper for the convolution fetch scheduler.
package conv_fetch_pkg;

    localparam int CF_DATA_W    = 20;
    localparam int CF_N_KER     = 32;
    localparam int CF_KER_ROWS  = 27;
    localparam int CF_KER_AW    = 5;
    localparam int CF_IMG_WORDS = 49152;
    localparam int CF_IMG_AW    = 16;
    localparam int CF_BIAS_ROWS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BIAS,
        S_LOAD_KER,
        S_STREAM_IMG,
        S_DRAIN,
        S_DONE
    } fetch_state_e;

    // A new read may issue only if the word it returns, plus the one already in flight,
    // still fits in the skid after this cycle's pop.
    function automatic logic slot_free(input logic [1:0] space, input logic pop, input logic pend);
        return ({1'b0, space} + {2'b00, pop}) > {2'b00, pend};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// Two-entry skid buffer; 'space' reports free entries and acts as the upstream ready.
module fetch_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic [1:0]   space,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy
);

    logic [1:0]   count;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign push    = in_vld && (count != 2'd2);
    assign pop     = out_vld && out_rdy;
    assign out_vld = (count != 2'd0);
    assign space   = 2'd2 - count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            out_data <= '0;
            tail     <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) out_data <= in_data;
                    else               tail     <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) out_data <= tail;
                    count <= count - 2'd1;
                end
                2'b11: out_data <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_fetch_sched.sv
// Sequences bias, kernel and image BRAM reads into three valid/ready streams, one phase at a time.
//
// state        | meaning
// S_IDLE       | waiting for start, busy low
// S_LOAD_BIAS  | reading bias rows 0..BIAS_ROWS-1
// S_LOAD_KER   | reading kernel rows 0..KER_ROWS-1 across all banks
// S_STREAM_IMG | reading image words 0..IMG_WORDS-1
// S_DRAIN      | waiting for the image stream to empty
// S_DONE       | one-cycle done pulse
module conv_fetch_sched
    import conv_fetch_pkg::*;
#(
    parameter int DATA_W    = CF_DATA_W,
    parameter int N_KER     = CF_N_KER,
    parameter int KER_ROWS  = CF_KER_ROWS,
    parameter int KER_AW    = CF_KER_AW,
    parameter int IMG_WORDS = CF_IMG_WORDS,
    parameter int IMG_AW    = CF_IMG_AW,
    parameter int BIAS_ROWS = CF_BIAS_ROWS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    ram_enable,
    output logic [KER_AW-1:0]       bias_addr,
    input  logic [DATA_W-1:0]       bias_rdata,
    output logic [KER_AW-1:0]       ker_addr,
    input  logic [N_KER*DATA_W-1:0] ker_rdata,
    output logic [IMG_AW-1:0]       img_addr,
    input  logic [DATA_W-1:0]       img_rdata,
    output logic [DATA_W-1:0]       bias_data,
    output logic [KER_AW-1:0]       bias_idx,
    output logic                    bias_vld,
    input  logic                    bias_rdy,
    output logic [N_KER*DATA_W-1:0] ker_data,
    output logic [KER_AW-1:0]       ker_row,
    output logic                    ker_vld,
    input  logic                    ker_rdy,
    output logic [DATA_W-1:0]       img_data,
    output logic                    img_vld,
    input  logic                    img_rdy
);

    localparam int KW = N_KER * DATA_W;

    fetch_state_e           state;
    logic                   bias_pend, ker_pend, img_pend;
    logic [KER_AW-1:0]      bias_pidx, ker_prow;
    logic [1:0]             bias_space, ker_space, img_space;
    logic                   bias_iss, ker_iss, img_iss;
    logic                   bias_empty, ker_empty, img_drained;
    logic [KER_AW+DATA_W-1:0] bias_q;
    logic [KER_AW+KW-1:0]     ker_q;

    assign bias_empty = !bias_vld && !bias_pend;
    assign ker_empty  = !ker_vld && !ker_pend;

    // A phase starts reading only once the previous stream has fully emptied.
    assign bias_iss = (state == S_LOAD_BIAS) && slot_free(bias_space, bias_vld && bias_rdy, bias_pend);
    assign ker_iss  = (state == S_LOAD_KER) && bias_empty
                      && slot_free(ker_space, ker_vld && ker_rdy, ker_pend);
    assign img_iss  = (state == S_STREAM_IMG) && ker_empty
                      && slot_free(img_space, img_vld && img_rdy, img_pend);
    assign ram_enable = bias_iss || ker_iss || img_iss;

    // True when the image skid will be empty after this edge, so done follows the final transfer.
    assign img_drained = !img_pend && (!img_vld || (img_space == 2'd1 && img_rdy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bias_addr <= '0;
            ker_addr  <= '0;
            img_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_LOAD_BIAS;
                    busy  <= 1'b1;
                end
                S_LOAD_BIAS: if (bias_iss) begin
                    if (bias_addr == KER_AW'(BIAS_ROWS - 1)) begin
                        bias_addr <= '0;
                        state     <= S_LOAD_KER;
                    end else begin
                        bias_addr <= bias_addr + KER_AW'(1);
                    end
                end
                S_LOAD_KER: if (ker_iss) begin
                    if (ker_addr == KER_AW'(KER_ROWS - 1)) begin
                        ker_addr <= '0;
                        state    <= S_STREAM_IMG;
                    end else begin
                        ker_addr <= ker_addr + KER_AW'(1);
                    end
                end
                S_STREAM_IMG: if (img_iss) begin
                    if (img_addr == IMG_AW'(IMG_WORDS - 1)) begin
                        img_addr <= '0;
                        state    <= S_DRAIN;
                    end else begin
                        img_addr <= img_addr + IMG_AW'(1);
                    end
                end
                S_DRAIN: if (img_drained) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-data return marker: BRAM data for an issued address is pushed one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_pend <= 1'b0;
            ker_pend  <= 1'b0;
            img_pend  <= 1'b0;
            bias_pidx <= '0;
            ker_prow  <= '0;
        end else begin
            bias_pend <= bias_iss;
            ker_pend  <= ker_iss;
            img_pend  <= img_iss;
            if (bias_iss) bias_pidx <= bias_addr;
            if (ker_iss)  ker_prow  <= ker_addr;
        end
    end

    fetch_skid #(.W(KER_AW + DATA_W)) u_bias_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (bias_pend),
        .in_data  ({bias_pidx, bias_rdata}),
        .space    (bias_space),
        .out_vld  (bias_vld),
        .out_data (bias_q),
        .out_rdy  (bias_rdy)
    );

    fetch_skid #(.W(KER_AW + KW)) u_ker_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (ker_pend),
        .in_data  ({ker_prow, ker_rdata}),
        .space    (ker_space),
        .out_vld  (ker_vld),
        .out_data (ker_q),
        .out_rdy  (ker_rdy)
    );

    fetch_skid #(.W(DATA_W)) u_img_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (img_pend),
        .in_data  (img_rdata),
        .space    (img_space),
        .out_vld  (img_vld),
        .out_data (img_data),
        .out_rdy  (img_rdy)
    );

    assign {bias_idx, bias_data} = bias_q;
    assign {ker_row, ker_data}   = ker_q;

endmodule

// File: tb/tb_conv_fetch_sched.sv
// Scoreboard bench for conv_fetch_sched: expected words queued at start, popped by a negedge monitor.
module tb_conv_fetch_sched;

    localparam int DW  = 20;
    localparam int NK  = 32;
    localparam int KR  = 27;
    localparam int KAW = 5;
    localparam int IW  = 1536;   // shortened image keeps the bench fast; address width unchanged
    localparam int IAW = 16;
    localparam int BR  = 32;
    localparam int KW  = NK * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, ram_enable;
    logic [KAW-1:0] bias_addr, ker_addr;
    logic [IAW-1:0] img_addr;
    logic [DW-1:0]  bias_rdata = '0;
    logic [DW-1:0]  img_rdata = '0;
    logic [KW-1:0]  ker_rdata = '0;
    logic [DW-1:0]  bias_data, img_data;
    logic [KAW-1:0] bias_idx, ker_row;
    logic [KW-1:0]  ker_data;
    logic           bias_vld, ker_vld, img_vld;
    logic           bias_rdy = 1'b1, ker_rdy = 1'b1, img_rdy = 1'b1;

    always #5 clk = ~clk;

    conv_fetch_sched #(
        .DATA_W(DW), .N_KER(NK), .KER_ROWS(KR), .KER_AW(KAW),
        .IMG_WORDS(IW), .IMG_AW(IAW), .BIAS_ROWS(BR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ram_enable(ram_enable),
        .bias_addr(bias_addr), .bias_rdata(bias_rdata),
        .ker_addr(ker_addr), .ker_rdata(ker_rdata),
        .img_addr(img_addr), .img_rdata(img_rdata),
        .bias_data(bias_data), .bias_idx(bias_idx), .bias_vld(bias_vld), .bias_rdy(bias_rdy),
        .ker_data(ker_data), .ker_row(ker_row), .ker_vld(ker_vld), .ker_rdy(ker_rdy),
        .img_data(img_data), .img_vld(img_vld), .img_rdy(img_rdy)
    );

    function automatic logic [DW-1:0] bias_word(input int i);
        return DW'(i * 37 + 'h0B100);
    endfunction

    function automatic logic [KW-1:0] ker_word(input int r);
        logic [KW-1:0] w;
        for (int b = 0; b < NK; b++) w[b*DW +: DW] = DW'(r * 256 + b + 'h40000);
        return w;
    endfunction

    function automatic logic [DW-1:0] img_word(input int a);
        return DW'(a * 5 + 'h123);
    endfunction

    // BRAM models, one-cycle read latency
    always @(posedge clk) begin
        if (ram_enable) begin
            bias_rdata <= bias_word(int'(bias_addr));
            ker_rdata  <= ker_word(int'(ker_addr));
            img_rdata  <= img_word(int'(img_addr));
        end
    end

    typedef struct packed { logic [KAW-1:0] idx; logic [DW-1:0] data; } bias_exp_t;
    typedef struct packed { logic [KAW-1:0] row; logic [KW-1:0] data; } ker_exp_t;

    bias_exp_t     bias_q[$];
    ker_exp_t      ker_q[$];
    logic [DW-1:0] img_q[$];

    int n_vec = 0;
    int n_err = 0;
    int bias_cnt = 0, ker_cnt = 0, img_cnt = 0, done_cnt = 0;
    logic           img_stall = 1'b0, ker_stall = 1'b0;
    logic [DW-1:0]  img_hold = '0;
    logic [KAW-1:0] ker_hold = '0;
    bias_exp_t      be;
    ker_exp_t       ke;
    logic [DW-1:0]  ie;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input int got, input int want);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Monitor: a word transfers at the next rising edge when vld&rdy are seen here.
    always @(negedge clk) begin
        if (!rst_n) begin
            img_stall = 1'b0;
            ker_stall = 1'b0;
        end else begin
            if (bias_vld && bias_rdy) begin
                if (bias_q.size() == 0) miss("bias_extra", bias_cnt, BR);
                else begin
                    be = bias_q.pop_front();
                    check("bias_idx", 64'(bias_idx), 64'(be.idx));
                    check("bias_data", 64'(bias_data), 64'(be.data));
                end
                bias_cnt++;
            end
            if (ker_vld && ker_rdy) begin
                if (ker_q.size() == 0) miss("ker_extra", ker_cnt, KR);
                else begin
                    ke = ker_q.pop_front();
                    check("ker_row", 64'(ker_row), 64'(ke.row));
                    check("ker_data_eq", 64'(ker_data === ke.data), 64'(1));
                end
                ker_cnt++;
            end
            if (img_vld && img_rdy) begin
                if (img_q.size() == 0) miss("img_extra", img_cnt, IW);
                else begin
                    ie = img_q.pop_front();
                    check("img_data", 64'(img_data), 64'(ie));
                end
                img_cnt++;
            end
            if (ker_stall) begin
                check("ker_hold_vld", 64'(ker_vld), 64'(1));
                check("ker_hold_row", 64'(ker_row), 64'(ker_hold));
            end
            if (img_stall) begin
                check("img_hold_vld", 64'(img_vld), 64'(1));
                check("img_hold_data", 64'(img_data), 64'(img_hold));
            end
            ker_stall = ker_vld && !ker_rdy;
            ker_hold  = ker_row;
            img_stall = img_vld && !img_rdy;
            img_hold  = img_data;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        bias_q.delete();
        ker_q.delete();
        img_q.delete();
        bias_cnt = 0;
        ker_cnt  = 0;
        img_cnt  = 0;
        done_cnt = 0;
    endtask

    // Start at edge T and check the T+1 / T+2 timing of the first bias word.
    task automatic start_checked();
        flush();
        for (int i = 0; i < BR; i++) bias_q.push_back(bias_exp_t'({KAW'(i), bias_word(i)}));
        for (int r = 0; r < KR; r++) ker_q.push_back(ker_exp_t'({KAW'(r), ker_word(r)}));
        for (int a = 0; a < IW; a++) img_q.push_back(img_word(a));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ram_enable_t1", 64'(ram_enable), 64'(1));
        check("bias_addr_t1", 64'(bias_addr), 64'(0));
        check("busy_t1", 64'(busy), 64'(1));
        check("bias_vld_t1", 64'(bias_vld), 64'(0));
        tick();
        check("bias_vld_t1_end", 64'(bias_vld), 64'(0));
        tick();
        check("bias_vld_t2", 64'(bias_vld), 64'(1));
        check("bias_idx_t2", 64'(bias_idx), 64'(0));
    endtask

    task automatic wait_done(input logic [3:0] pat, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            img_rdy = pat[c % 4];
            tick();
            c++;
        end
        img_rdy = 1'b1;
        if (!done) miss("done_timeout", c, budget);
        else begin
            check("busy_with_done", 64'(busy), 64'(1));
            tick();
            check("done_one_cycle", 64'(done), 64'(0));
            check("busy_after_done", 64'(busy), 64'(0));
        end
    endtask

    task automatic end_run(input string tag);
        check({tag, "_bias_count"}, 64'(bias_cnt), 64'(BR));
        check({tag, "_ker_count"}, 64'(ker_cnt), 64'(KR));
        check({tag, "_img_count"}, 64'(img_cnt), 64'(IW));
        check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_ram_enable"}, 64'(ram_enable), 64'(0));
        check({tag, "_bias_vld"}, 64'(bias_vld), 64'(0));
        check({tag, "_ker_vld"}, 64'(ker_vld), 64'(0));
        check({tag, "_img_vld"}, 64'(img_vld), 64'(0));
        check({tag, "_bias_addr"}, 64'(bias_addr), 64'(0));
        check({tag, "_ker_addr"}, 64'(ker_addr), 64'(0));
        check({tag, "_img_addr"}, 64'(img_addr), 64'(0));
        check({tag, "_bias_idx"}, 64'(bias_idx), 64'(0));
        check({tag, "_ker_row"}, 64'(ker_row), 64'(0));
        check({tag, "_img_data"}, 64'(img_data), 64'(0));
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        #3;
        check_reset_outputs("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full run at rdy=1, with a stray start during image streaming
        start_checked();
        c = 0;
        while (img_cnt < 100 && c < 5000) begin tick(); c++; end
        if (img_cnt < 100) miss("reach_img100", img_cnt, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_stray_start", 64'(busy), 64'(1));
        wait_done(4'b1111, 20000);
        end_run("run_a");

        // img_rdy pattern 1,0,0,1
        tick();
        start_checked();
        wait_done(4'b1001, 20000);
        end_run("run_b");

        // Kernel stall at row 5 for 10 cycles
        tick();
        start_checked();
        c = 0;
        while (!(ker_vld && ker_row == KAW'(5)) && c < 500) begin tick(); c++; end
        if (!(ker_vld && ker_row == KAW'(5))) miss("reach_ker_row5", int'(ker_row), 5);
        ker_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ker_row_held", 64'(ker_row), 64'(5));
            check("ker_addr_le7", 64'(ker_addr <= KAW'(7)), 64'(1));
        end
        ker_rdy = 1'b1;
        wait_done(4'b1111, 20000);
        end_run("run_c");

        // Reset at image word 1000, then restart from bias 0
        tick();
        start_checked();
        c = 0;
        while (img_cnt < 1000 && c < 5000) begin tick(); c++; end
        if (img_cnt < 1000) miss("reach_img1000", img_cnt, 1000);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        flush();
        tick();
        rst_n = 1'b1;
        tick();
        start_checked();
        wait_done(4'b1111, 20000);
        end_run("run_d");

        // Last image word held 3 cycles; done follows the final transfer
        tick();
        start_checked();
        c = 0;
        while (!(img_vld && img_data == img_word(IW - 1)) && c < 5000) begin tick(); c++; end
        if (!(img_vld && img_data == img_word(IW - 1))) miss("reach_last_img", img_cnt, IW - 1);
        img_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_done_low", 64'(done), 64'(0));
            check("drain_busy_high", 64'(busy), 64'(1));
            check("last_img_vld", 64'(img_vld), 64'(1));
        end
        img_rdy = 1'b1;
        tick();
        check("done_after_last", 64'(done), 64'(1));
        tick();
        check("done_pulse_end", 64'(done), 64'(0));
        check("busy_end", 64'(busy), 64'(0));
        end_run("run_e");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
